bcd_capture: RTL and testbench
==============================

BCD_CAPTURE -- requirements
Module: bcd_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, legal 1..15: consecutive identical synchronized samples required before a digit is committed.
REQ-002 The block SHALL have port clk_i, input, 1, the single system clock (rising edge).
REQ-003 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port bcd_i, input, 4, asynchronous ripple-counter outputs {QD,QC,QB,QA}.
REQ-005 The block SHALL have port clr_i, input, 1, synchronous clear of counts, flags and handshake.
REQ-006 The block SHALL have port digit_o, output, 4, last committed digit 0..9.
REQ-007 The block SHALL have port tens_o, output, 4, BCD count of decade wraps 0..9.
REQ-008 The block SHALL have port valid_o, output, 1, digit_o/tens_o hold an unconsumed update.
REQ-009 The block SHALL have port ready_i, input, 1, consumer accepts the update when valid_o and ready_i are both high.
REQ-010 The block SHALL have port carry_o, output, 1, one-cycle pulse on each 9->0 commit.
REQ-011 The block SHALL have port err_o, output, 3, sticky flags {overrun, skip, illegal}.
REQ-012 The block SHALL have port ovf_o, output, 1, sticky flag: tens wrapped 9->0.

Function
REQ-013 The block SHALL pass bcd_i through a 2-flop synchronizer, each bit independently.
REQ-014 The block SHALL hold a 4-bit stability counter: reset to 0 when the synchronized value differs from its previous-cycle value, otherwise increment, saturating at STABLE_CYCLES.
REQ-015 The block SHALL treat the synchronized value as stable in the cycle the counter first reaches STABLE_CYCLES; it SHALL evaluate a stable value once only.
REQ-016 The block SHALL ignore a stable value equal to the last committed digit.
REQ-017 The block SHALL treat a stable value of 10..15 as illegal: set err_o[0], make no commit, leave digit_o unchanged.
REQ-018 The block SHALL commit a stable legal value V differing from last digit L; digit_o <= V.
REQ-019 A commit SHALL set err_o[1] if V != (L+1) mod 10; it SHALL then assert no carry and leave tens unchanged.
REQ-020 A commit with L=9, V=0 SHALL pulse carry_o in the commit cycle and increment tens_o mod 10.
REQ-021 A tens wrap 9->0 SHALL set ovf_o.
REQ-022 Latency from a bcd_i change to its commit SHALL be 2+STABLE_CYCLES clk_i cycles; digit_o, valid_o and carry_o SHALL update on that same edge.
REQ-023 A commit SHALL set valid_o; valid_o SHALL remain high until a cycle with ready_i high, then clear.
REQ-024 A commit while valid_o=1 and ready_i=0 SHALL set err_o[2]; digit_o and tens_o SHALL still update to the new values.
REQ-025 A commit in the same cycle that the consumer accepts (valid_o=1, ready_i=1) SHALL keep valid_o high and SHALL NOT set err_o[2].
REQ-026 clr_i SHALL clear tens_o, err_o, ovf_o, valid_o and carry_o; last digit SHALL load the current synchronized value if 0..9, else 0; no commit occurs in that cycle; clr_i has priority over a simultaneous commit.

Reset
REQ-027 rst_i SHALL asynchronously clear the synchronizer flops, stability counter, digit_o, tens_o, valid_o, carry_o, err_o and ovf_o to 0.
REQ-028 The first commit after reset SHALL compare against L=0.
REQ-029 Reset asserted mid-filter SHALL discard the partially filtered value; after release the filter restarts from count 0.

Structure
REQ-030 Package bcd_capture_pkg SHALL hold BCD_W=4, BCD_MAX=9, STABLE_CYCLES_DEF=4, and error-bit index constants ERR_ILLEGAL=0, ERR_SKIP=1, ERR_OVERRUN=2.
REQ-031 The block SHALL instantiate one sub-module, bcd_sync2: a 2-flop, per-bit synchronizer with the same clk_i and rst_i.

Verification
REQ-032 Reset, then bcd_i steps 0->1->...->9->0, each held 10 cycles, ready_i=1 -> ten commits, each 6 cycles after its change, carry_o pulses once, tens_o=1, err_o=0.
REQ-033 bcd_i toggles 3->7->3 with 2-cycle dwell, then holds 4 -> no commit during the glitches, single commit digit_o=4, err_o[1]=1 (L=0->4 skip).
REQ-034 bcd_i held at 12 -> err_o[0]=1, digit_o unchanged, valid_o stays 0.
REQ-035 ready_i=0, two legal increments 1 then 2 -> valid_o=1, digit_o=2, err_o[2]=1; raise ready_i for one cycle -> valid_o=0.
REQ-036 Run 100 wraps -> tens_o=0, ovf_o=1; pulse clr_i with bcd_i=5 -> all flags 0; next step 5->6 commits with no skip error.
REQ-037 rst_i asserted asynchronously mid-filter (count=2), then released -> all outputs 0 immediately; the held value commits 2+STABLE_CYCLES cycles after release.

Source files
------------

// File: rtl/bcd_capture_pkg.sv
// Shared types, constants and digit helpers for the BCD capture block.
package bcd_capture_pkg;

    localparam int BCD_W             = 4;
    localparam int ERR_W             = 3;
    localparam int STABLE_CYCLES_DEF = 4;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_SKIP    = 1;
    localparam int ERR_OVERRUN = 2;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = bcd_t'(9);

    function automatic logic is_digit(bcd_t v);
        return v <= BCD_MAX;
    endfunction

    function automatic bcd_t next_digit(bcd_t v);
        return (v == BCD_MAX) ? bcd_t'(0) : v + bcd_t'(1);
    endfunction

endpackage

// File: rtl/bcd_capture_if.sv
// Result/handshake bundle between the capture block and its consumer.
interface bcd_capture_if;
    import bcd_capture_pkg::*;

    bcd_t             digit_o;
    bcd_t             tens_o;
    logic             valid_o;
    logic             ready_i;
    logic             carry_o;
    logic [ERR_W-1:0] err_o;
    logic             ovf_o;

    modport master (
        output digit_o, tens_o, valid_o, carry_o, err_o, ovf_o,
        input  ready_i
    );

    modport slave (
        input  digit_o, tens_o, valid_o, carry_o, err_o, ovf_o,
        output ready_i
    );

endinterface

// File: rtl/bcd_capture_sync2.sv
// Two-flop synchronizer; each bit resolves independently, both stages visible.
module bcd_sync2 #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q_p0,
    output logic [W-1:0] q_p1
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_p0 <= '0;
            q_p1 <= '0;
        end else begin
            q_p0 <= d;
            q_p1 <= q_p0;
        end
    end

endmodule

// File: rtl/bcd_capture.sv
// Captures an asynchronous ripple-counter BCD digit: synchronize, debounce,
// commit new digits, count decade wraps and flag anomalies.
module bcd_capture
    import bcd_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BCD_W-1:0] bcd_i,
    input  logic          clr_i,
    bcd_capture_if.master cap
);

    localparam logic [3:0] CNT_SAT  = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_EVAL = 4'(STABLE_CYCLES - 1);

    bcd_t             sync_p0;
    bcd_t             sync_p1;
    logic [3:0]       stab_cnt;
    bcd_t             digit;
    bcd_t             tens;
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [ERR_W-1:0] err;

    logic changing;
    logic stable;
    logic legal;
    logic commit;
    logic wrap;
    logic skip;

    bcd_sync2 #(.W(BCD_W)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (bcd_i),
        .q_p0  (sync_p0),
        .q_p1  (sync_p1)
    );

    // Stability filter. The first stage predicts the next synchronized value,
    // so the counter clears on the same edge the synchronized value changes.
    assign changing = (sync_p0 != sync_p1);
    assign stable   = !changing && (stab_cnt == CNT_EVAL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stab_cnt <= '0;
        end else if (changing) begin
            stab_cnt <= '0;
        end else if (stab_cnt != CNT_SAT) begin
            stab_cnt <= stab_cnt + 4'd1;
        end
    end

    // Commit decision on the filtered value.
    assign legal  = is_digit(sync_p1);
    assign commit = stable && legal && (sync_p1 != digit);
    assign wrap   = commit && (digit == BCD_MAX) && (sync_p1 == bcd_t'(0));
    assign skip   = commit && (sync_p1 != next_digit(digit));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit <= '0;
            tens  <= '0;
            valid <= 1'b0;
            carry <= 1'b0;
            err   <= '0;
            ovf   <= 1'b0;
        end else if (clr_i) begin
            digit <= legal ? sync_p1 : bcd_t'(0);
            tens  <= '0;
            valid <= 1'b0;
            carry <= 1'b0;
            err   <= '0;
            ovf   <= 1'b0;
        end else begin
            carry <= wrap;
            if (stable && !legal) begin
                err[ERR_ILLEGAL] <= 1'b1;
            end
            if (commit) begin
                digit <= sync_p1;
                valid <= 1'b1;
                if (skip) begin
                    err[ERR_SKIP] <= 1'b1;
                end
                if (valid && !cap.ready_i) begin
                    err[ERR_OVERRUN] <= 1'b1;
                end
            end else if (cap.ready_i) begin
                valid <= 1'b0;
            end
            if (wrap) begin
                tens <= next_digit(tens);
                if (tens == BCD_MAX) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign cap.digit_o = digit;
    assign cap.tens_o  = tens;
    assign cap.valid_o = valid;
    assign cap.carry_o = carry;
    assign cap.err_o   = err;
    assign cap.ovf_o   = ovf;

endmodule

// File: tb/tb_bcd_capture.sv
// Bench for bcd_capture: vector table, corner sequences, random run vs. model.
module tb_bcd_capture;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd = 4'd0;
    logic       clr = 1'b0;
    logic       ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_cnt = 0;
    int carry_cnt = 0;

    bcd_capture_if cap_if ();
    assign cap_if.ready_i = ready;

    bcd_capture #(.STABLE_CYCLES(S)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bcd_i (bcd),
        .clr_i (clr),
        .cap   (cap_if)
    );

    always #5 clk = ~clk;

    // Reference model: a value is evaluated when the sample stream (delayed two
    // edges by the synchronizer) shows exactly S+1 identical samples after a change.
    int       hist[$];
    int       m_l, m_tens;
    bit       m_valid, m_carry, m_ovf;
    bit [2:0] m_err;

    function automatic void m_reset();
        hist.delete();
        hist.push_back(99);
        hist.push_back(0);
        hist.push_back(0);
        m_l = 0; m_tens = 0; m_valid = 0; m_carry = 0; m_ovf = 0; m_err = 3'b000;
    endfunction

    function automatic void m_step(int b, bit c, bit r);
        int e;
        int v;
        bit ev;
        hist.push_back(b);
        while (hist.size() > S + 3) void'(hist.pop_front());
        e  = hist.size() - 1;
        v  = hist[e-1];
        ev = (e - 2 - S >= 0);
        if (ev) begin
            for (int k = 1; k <= S + 1; k++) if (hist[e-k] != v) ev = 0;
            if (hist[e-2-S] == v) ev = 0;
        end
        if (c) begin
            m_tens = 0; m_err = 3'b000; m_ovf = 0; m_valid = 0; m_carry = 0;
            m_l = (hist[e-2] <= 9) ? hist[e-2] : 0;
            return;
        end
        m_carry = 0;
        if (ev && v > 9) m_err[0] = 1;
        if (ev && v <= 9 && v != m_l) begin
            if (v != (m_l + 1) % 10) m_err[1] = 1;
            if (m_l == 9 && v == 0) begin
                m_carry = 1;
                if (m_tens == 9) m_ovf = 1;
                m_tens = (m_tens + 1) % 10;
            end
            if (m_valid && !r) m_err[2] = 1;
            m_valid = 1;
            m_l = v;
        end else if (r) begin
            m_valid = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step(int'(bcd), clr, ready);
    end

    function automatic logic [13:0] dut_vec();
        return {cap_if.digit_o, cap_if.tens_o, cap_if.valid_o, cap_if.carry_o,
                cap_if.err_o, cap_if.ovf_o};
    endfunction

    function automatic logic [13:0] mdl_vec();
        return {4'(m_l), 4'(m_tens), m_valid, m_carry, m_err, m_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (cap_if.valid_o) vld_cnt++;
        if (cap_if.carry_o) carry_cnt++;
        check("model", 32'(dut_vec()), 32'(mdl_vec()));
    endtask

    task automatic do_reset();
        rst = 1'b1; bcd = 4'd0; clr = 1'b0; ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_digit(input int want, input int limit, output int n);
        n = 0;
        while (int'(cap_if.digit_o) != want && n < limit) begin
            cyc();
            n++;
        end
    endtask

    typedef struct {
        int bcd;
        int hold;
        bit rdy;
        bit clr;
        int e_digit;
        int e_tens;
        bit e_valid;
        int e_err;
        bit e_ovf;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        int b;
        int prev_b;

        for (int i = 0; i < 9; i++) tbl[i] = '{i + 1, 10, 1'b1, 1'b0, i + 1, 0, 1'b0, 0, 1'b0};
        tbl[9]  = '{0,  10, 1'b1, 1'b0, 0, 1, 1'b0, 0, 1'b0};
        tbl[10] = '{12, 10, 1'b1, 1'b0, 0, 1, 1'b0, 1, 1'b0};
        tbl[11] = '{12, 1,  1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0};
        tbl[12] = '{5,  10, 1'b1, 1'b0, 5, 0, 1'b0, 2, 1'b0};
        tbl[13] = '{7,  10, 1'b1, 1'b0, 7, 0, 1'b0, 2, 1'b0};

        rst = 1'b1;
        do_reset();
        check("reset_state", 32'(dut_vec()), 32'd0);

        // Digit walk, illegal hold, clear and skips.
        carry_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            bcd = 4'(tbl[i].bcd); ready = tbl[i].rdy; clr = tbl[i].clr;
            repeat (tbl[i].hold) cyc();
            clr = 1'b0;
            check($sformatf("vec%0d", i),
                  {19'd0, cap_if.digit_o, cap_if.tens_o, cap_if.valid_o, cap_if.err_o, cap_if.ovf_o},
                  {19'd0, 4'(tbl[i].e_digit), 4'(tbl[i].e_tens), tbl[i].e_valid,
                   3'(tbl[i].e_err), tbl[i].e_ovf});
        end
        check("carry_pulses", carry_cnt, 1);

        // Change-to-commit latency.
        do_reset();
        bcd = 4'd3;
        wait_digit(3, 20, n);
        check("latency", n, S + 2);

        // Glitches shorter than the filter never commit.
        do_reset();
        vld_cnt = 0;
        bcd = 4'd3; repeat (2) cyc();
        bcd = 4'd7; repeat (2) cyc();
        bcd = 4'd3; repeat (2) cyc();
        bcd = 4'd4; repeat (12) cyc();
        check("glitch_commits", vld_cnt, 1);
        check("glitch_result", {cap_if.digit_o, cap_if.err_o}, {4'd4, 3'b010});

        // Overrun with the consumer stalled, then accept.
        do_reset();
        ready = 1'b0;
        bcd = 4'd1; repeat (8) cyc();
        bcd = 4'd2; repeat (8) cyc();
        check("overrun", {cap_if.valid_o, cap_if.digit_o, cap_if.err_o}, {1'b1, 4'd2, 3'b100});
        ready = 1'b1; cyc(); ready = 1'b0;
        check("accept_clears", cap_if.valid_o, 1'b0);

        // Commit coinciding with accept keeps valid without overrun.
        clr = 1'b1; cyc(); clr = 1'b0;
        check("clr_loads_digit", {cap_if.digit_o, cap_if.err_o, cap_if.valid_o}, {4'd2, 3'b000, 1'b0});
        bcd = 4'd3; repeat (8) cyc();
        bcd = 4'd4; repeat (5) cyc();
        ready = 1'b1; cyc();
        check("commit_on_accept", {cap_if.valid_o, cap_if.digit_o, cap_if.err_o}, {1'b1, 4'd4, 3'b000});
        cyc();
        check("accept_after", cap_if.valid_o, 1'b0);

        // 100 decade wraps, then clear.
        do_reset();
        for (int w = 0; w < 100; w++) begin
            for (int d = 1; d <= 10; d++) begin
                bcd = 4'(d % 10);
                repeat (7) cyc();
            end
        end
        check("wrap_tens_ovf", {cap_if.tens_o, cap_if.ovf_o}, {4'd0, 1'b1});
        bcd = 4'd5; repeat (8) cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        check("clr_flags", {cap_if.digit_o, cap_if.tens_o, cap_if.valid_o, cap_if.carry_o,
                            cap_if.err_o, cap_if.ovf_o}, {4'd5, 10'd0});
        bcd = 4'd6; repeat (8) cyc();
        check("after_clr_step", {cap_if.digit_o, cap_if.err_o}, {4'd6, 3'b000});

        // Asynchronous reset mid-filter.
        do_reset();
        bcd = 4'd3; repeat (8) cyc();
        bcd = 4'd7; repeat (4) cyc();
        #3 rst = 1'b1;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        #2 rst = 1'b0;
        wait_digit(7, 20, n);
        check("post_reset_latency", n, S + 2);

        // Random stimulus against the model.
        do_reset();
        prev_b = 0;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 9) == 0)      b = $urandom_range(10, 15);
            else if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 9);
            else                                b = (prev_b + 1) % 10;
            prev_b = (b <= 9) ? b : prev_b;
            bcd = 4'(b);
            for (int c = $urandom_range(1, 9); c > 0; c--) begin
                ready = 1'($urandom_range(0, 1));
                clr   = ($urandom_range(0, 40) == 0);
                cyc();
            end
            clr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
